// File: rtl/lcd_pkg.sv
// Shared LCD controller definitions: state encoding, op codes, bus bit constants
// and small helpers used by the reader (and reusable by the writer).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } lcd_state_e;

  localparam logic [1:0] OP_STATUS = 2'b00;
  localparam logic [1:0] OP_DATA   = 2'b01;
  localparam logic [1:0] OP_WAIT   = 2'b10;

  localparam int   BF_BIT  = 7;
  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;
  localparam logic RW_WR   = 1'b0;
  localparam logic RW_RD   = 1'b1;

  // The reserved op code behaves as a status read.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == 2'b11) ? OP_STATUS : op;
  endfunction

  function automatic logic [7:0] phase_load(input int unsigned cyc);
    return 8'(cyc - 1);
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable 8-bit down-counter; expired_o is high while the count sits at zero.
module lcd_phase_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       expired_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == 8'd0);

endmodule

// File: rtl/lcd_status_reader.sv
// HD44780-style read-cycle engine: status/data reads and busy-flag polling.
// Define LCD_RD_4BIT_EN for 4-bit bus mode (two nibble strobes per read).
module lcd_status_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned EN_HI_CYC = 4,
  parameter int unsigned HOLD_CYC  = 2,
  parameter int unsigned GAP_CYC   = 3,
  parameter int unsigned MAX_POLLS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] lcd_din,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic       bus_own,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       lcd_busy,
  output logic       timeout
);

  localparam logic [7:0] MAX_POLLS_8 = 8'(MAX_POLLS);

  lcd_state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [7:0] poll_q, poll_d;
  logic       timeout_q, timeout_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       lcd_busy_q, lcd_busy_d;
  logic       rs_q, rs_d, rw_q, rw_d, en_q, en_d;
  logic       bus_own_q, bus_own_d, busy_q, busy_d, done_q, done_d;
  logic       last_nib;

  logic       tmr_load, tmr_expired;
  logic [7:0] tmr_val;

`ifdef LCD_RD_4BIT_EN
  logic nib_q, nib_d;
  logic unused_low_nibble;
  assign unused_low_nibble = ^lcd_din[3:0];
  assign last_nib = nib_q;
`else
  assign last_nib = 1'b1;
`endif

  lcd_phase_timer u_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // Next-state and data-path updates.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    poll_d     = poll_q;
    timeout_d  = timeout_q;
    rd_data_d  = rd_data_q;
    lcd_busy_d = lcd_busy_q;
`ifdef LCD_RD_4BIT_EN
    nib_d      = nib_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = norm_op(op);
          timeout_d = 1'b0;
          poll_d    = 8'd0;
`ifdef LCD_RD_4BIT_EN
          nib_d     = 1'b0;
`endif
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) state_d = ST_EN_HI;
      end
      ST_EN_HI: begin
        if (tmr_expired) begin
`ifdef LCD_RD_4BIT_EN
          if (!nib_q) begin
            rd_data_d[7:4] = lcd_din[7:4];
            lcd_busy_d     = (op_q == OP_DATA) ? 1'b0 : lcd_din[7];
          end else begin
            rd_data_d[3:0] = lcd_din[7:4];
          end
`else
          rd_data_d  = lcd_din;
          lcd_busy_d = (op_q == OP_DATA) ? 1'b0 : lcd_din[BF_BIT];
`endif
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_expired) begin
          if (!last_nib) begin
`ifdef LCD_RD_4BIT_EN
            nib_d = 1'b1;
`endif
            state_d = ST_SETUP;
          end else if (op_q == OP_WAIT && rd_data_q[BF_BIT]) begin
            poll_d = poll_q + 8'd1;
            if (poll_d == MAX_POLLS_8) begin
              timeout_d = 1'b1;
              state_d   = ST_DONE;
            end else begin
              state_d   = ST_GAP;
            end
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
`ifdef LCD_RD_4BIT_EN
          nib_d = 1'b0;
`endif
          state_d = ST_SETUP;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up
  // with the state they belong to.
  always_comb begin
    rs_d      = RS_CMD;
    rw_d      = RW_WR;
    en_d      = 1'b0;
    bus_own_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_d)
      ST_SETUP, ST_EN_HI, ST_HOLD, ST_GAP: begin
        bus_own_d = 1'b1;
        busy_d    = 1'b1;
        rw_d      = RW_RD;
        rs_d      = (op_d == OP_DATA) ? RS_DATA : RS_CMD;
        en_d      = (state_d == ST_EN_HI);
      end
      ST_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    tmr_load = (state_d != state_q);
    unique case (state_d)
      ST_SETUP: tmr_val = phase_load(SETUP_CYC);
      ST_EN_HI: tmr_val = phase_load(EN_HI_CYC);
      ST_HOLD:  tmr_val = phase_load(HOLD_CYC);
      ST_GAP:   tmr_val = phase_load(GAP_CYC);
      default:  tmr_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_STATUS;
      poll_q     <= 8'd0;
      timeout_q  <= 1'b0;
      rd_data_q  <= 8'd0;
      lcd_busy_q <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      en_q       <= 1'b0;
      bus_own_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      poll_q     <= poll_d;
      timeout_q  <= timeout_d;
      rd_data_q  <= rd_data_d;
      lcd_busy_q <= lcd_busy_d;
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      en_q       <= en_d;
      bus_own_q  <= bus_own_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef LCD_RD_4BIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) nib_q <= 1'b0;
    else     nib_q <= nib_d;
  end
`endif

  assign rs       = rs_q;
  assign rw       = rw_q;
  assign en       = en_q;
  assign bus_own  = bus_own_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign lcd_busy = lcd_busy_q;
  assign timeout  = timeout_q;

endmodule

// File: doc/lcd_status_reader.md
Name: lcd_status_reader

Overview:
- Read-side companion to the LCD write controller. Runs HD44780-style read cycles (rw=1) on the shared LCD bus.
- Status read (rs=0): returns busy flag D7 and address counter D6..D0.
- Data read (rs=1): returns the DDRAM/CGRAM byte.
- Wait-ready mode: polls the busy flag until clear, so the writer sequence can gate each command on the controller being ready instead of using fixed delays.
- The top level muxes rs/rw/en between writer and reader using bus_own.

Parameters:
- SETUP_CYC, 2: clocks rs/rw are stable before en rises (tAS); must be >= 1.
- EN_HI_CYC, 4: clocks en is held high; must be >= 1.
- HOLD_CYC, 2: clocks rs/rw are held after en falls; must be >= 1.
- GAP_CYC, 3: idle clocks between polls in wait-ready mode; must be >= 1.
- MAX_POLLS, 16: poll limit before timeout; must be >= 1.
- Constraint: all counts must fit 8 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00 status read, 01 data read, 10 wait-ready poll, 11 reserved (treated as 00)
- lcd_din  in  8  LCD data bus input (pad side, tristated by top)
- rs  out  1  register select to LCD
- rw  out  1  read/write to LCD (1 = read)
- en  out  1  enable strobe to LCD
- bus_own  out  1  1 while this block drives rs/rw/en; top releases data pads and selects reader
- busy  out  1  1 from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- rd_data  out  8  last sampled byte; held until next sample
- lcd_busy  out  1  rd_data[7] for status reads and polls
- timeout  out  1  set with done when wait-ready exhausts MAX_POLLS; cleared on next accepted start

Behaviour:
- Reset (async, immediate): state=IDLE; rs=0, rw=0, en=0, bus_own=0, busy=0, done=0, rd_data=0, lcd_busy=0, timeout=0; counters cleared.
- Reset mid-cycle: en drops in the same instant; no done is produced.
- All outputs are registered.
- States: IDLE, SETUP, EN_HI, HOLD, GAP, DONE.
- IDLE:
  - start=1 latches op, clears timeout and clears the poll counter, then goes to SETUP.
  - start is ignored in every other state. There is no queueing.
- SETUP (SETUP_CYC clocks): bus_own=1, rw=1, en=0. rs=1 only for op 01, otherwise 0.
- EN_HI (EN_HI_CYC clocks): en=1. lcd_din is captured into rd_data at the clock edge ending the last EN_HI cycle.
- HOLD (HOLD_CYC clocks): en=0, with rs and rw held.
  - op 00/01 go to DONE.
  - op 10 with captured D7=0 goes to DONE.
  - op 10 with D7=1 increments the poll counter. If the count equals MAX_POLLS, set timeout and go to DONE; otherwise go to GAP.
- GAP (GAP_CYC clocks): bus_own stays 1, rw=1, en=0. Then go to SETUP.
- DONE (1 clock): done=1, busy=1; rs=0, rw=0, bus_own=0. Then IDLE, where busy=0.
- Latency for a single read: start sampled at edge t means SETUP occupies cycles t+1..t+S and done is high in cycle t+S+E+H+1. With defaults this is t+9.
- Latency for a poll: each extra poll adds GAP_CYC+SETUP_CYC+EN_HI_CYC+HOLD_CYC clocks (11 with defaults).
- Phase counter: 8-bit down-counter loaded on each state entry with (count-1). State advances when it reaches 0.
- lcd_busy updates together with rd_data. For op 01 it is forced to 0.
- en is never high while rs or rw is changing.

Optional Feature:
- Macro: LCD_RD_4BIT_EN.
- Defined (4-bit bus mode, only lcd_din[7:4] is meaningful):
  - Each read performs two en pulses separated by one HOLD+SETUP pair.
  - The first pulse captures rd_data[7:4]; the second captures rd_data[3:0].
  - The busy decision in poll mode uses the first nibble's bit 3 (D7).
  - The second nibble is still read so the LCD nibble phase stays aligned.
- Undefined: single 8-bit cycle, and lcd_din[3:0] is used.

Decomposition:
- Shared package lcd_pkg holds:
  - the state encoding typedef (shared with the writer's state type naming);
  - op codes OP_STATUS=2'b00, OP_DATA=2'b01, OP_WAIT=2'b10;
  - LCD bit constants BF_BIT=7, RS_CMD=0, RS_DATA=1, RW_WR=0, RW_RD=1.
- Sub-module lcd_phase_timer: loadable 8-bit down-counter with an expire flag, reusable by the writer.

Test Plan:
- Reset: assert rst mid-EN_HI → en=0 asynchronously; all outputs at reset values; no done.
- Status read: op=00, lcd_din=8'h45 during EN_HI, start at t.
  - rs=0, rw=1, en high for cycles t+3..t+6.
  - done at t+9; rd_data=8'h45, lcd_busy=0.
- Data read: op=01, lcd_din=8'hA7 → rs=1 throughout; rd_data=8'hA7, lcd_busy=0; done at t+9.
- Wait-ready: op=10, D7=1 for the first 3 polls then lcd_din=8'h12 → 4 en pulses; done at t+9+3*11=t+42; rd_data=8'h12, timeout=0.
- Timeout: op=10, lcd_din stuck 8'h80 → exactly 16 en pulses; then done with timeout=1, lcd_busy=1. The next start clears timeout.
- Start while busy is ignored: no second cycle and exactly one done. With LCD_RD_4BIT_EN, lcd_din[7:4]=4'h3 then 4'hC → rd_data=8'h3C.
